// File: rtl/bpu_btb_assoc_if.sv
// bpu_btb_assoc_if: fetch-side lookup, redirect and EX-side update bundle for the BTB.
interface bpu_btb_assoc_if #(parameter int ADDR_WIDTH = 32);
  logic                  EN;
  logic [ADDR_WIDTH-1:0] PC;
  logic [ADDR_WIDTH-1:0] PRD_ADDR;
  logic                  PRD_TAKEN;
  logic                  PRD_REDIRECT;
  logic                  UPD_VALID;
  logic [ADDR_WIDTH-1:0] UPD_PC;
  logic                  UPD_TAKEN;
  logic [ADDR_WIDTH-1:0] UPD_TARGET;
  logic [1:0]            UPD_KIND;
  logic                  UPD_IS_CALL;
  logic                  UPD_MISPRED;
  logic [31:0]           BR_COUNT;
  logic [31:0]           MISPRED_COUNT;
  modport master (
    output EN, PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET, UPD_KIND, UPD_IS_CALL, UPD_MISPRED,
    input  PRD_ADDR, PRD_TAKEN, PRD_REDIRECT, BR_COUNT, MISPRED_COUNT
  );
  modport slave (
    input  EN, PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET, UPD_KIND, UPD_IS_CALL, UPD_MISPRED,
    output PRD_ADDR, PRD_TAKEN, PRD_REDIRECT, BR_COUNT, MISPRED_COUNT
  );
endinterface

// File: rtl/bpu_btb_assoc.sv
// bpu_btb_assoc: set-associative BTB with 2-bit counters, round-robin replacement,
// commit-side return stack and same-cycle misprediction redirect.
module bpu_btb_assoc #(
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 256,
  parameter int WAYS       = 2,
  parameter int RAS_DEPTH  = 8
) (
  input logic CLK,
  input logic RST_N,
  bpu_btb_assoc_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);
  logic [WAYS-1:0]       valid_q [SETS];
  logic [1:0]            ctr_q   [SETS][WAYS];
  logic [WAY_W-1:0]      vptr_q  [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] tgt_q   [SETS][WAYS];
  logic [1:0]            kind_q  [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] ras_q   [RAS_DEPTH];
  logic [RAS_W-1:0]      ras_top, ras_wr_idx;
  logic [RAS_W:0]        ras_cnt;
  logic [31:0]           br_cnt, mp_cnt;
  logic [IDX_W-1:0] l_set, u_set;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, u_free;
  logic [WAY_W-1:0] l_way, u_way, u_inv, u_w;
  logic [1:0]       l_kind, u_ctr, u_ctr_nx;
  logic             l_taken, redir, upd, u_wr, push, pop;
  logic [ADDR_WIDTH-1:0] l_tgt;
  assign l_set = bus.PC[IDX_W+1:2];
  assign l_tag = bus.PC[ADDR_WIDTH-1:IDX_W+2];
  assign u_set = bus.UPD_PC[IDX_W+1:2];
  assign u_tag = bus.UPD_PC[ADDR_WIDTH-1:IDX_W+2];
  // Descending scan so the lowest matching / lowest invalid way is the one left standing.
  always_comb begin
    l_hit = 1'b0;
    l_way = '0;
    u_hit = 1'b0;
    u_way = '0;
    u_free = 1'b0;
    u_inv = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid_q[l_set][i] && tag_q[l_set][i] == l_tag) begin
        l_hit = 1'b1;
        l_way = WAY_W'(i);
      end
      if (valid_q[u_set][i] && tag_q[u_set][i] == u_tag) begin
        u_hit = 1'b1;
        u_way = WAY_W'(i);
      end
      if (!valid_q[u_set][i]) begin
        u_free = 1'b1;
        u_inv = WAY_W'(i);
      end
    end
  end
  assign l_kind  = kind_q[l_set][l_way];
  assign l_taken = l_hit && (l_kind == 2'b01 || (l_kind == 2'b10 ? ras_cnt != '0 : ctr_q[l_set][l_way][1]));
  assign l_tgt   = l_kind == 2'b10 ? ras_q[ras_top] : tgt_q[l_set][l_way];
  assign redir   = bus.UPD_VALID && bus.UPD_MISPRED;
  assign bus.PRD_REDIRECT  = redir;
  assign bus.PRD_TAKEN     = !redir && l_taken;
  assign bus.PRD_ADDR      = redir ? (bus.UPD_TAKEN ? bus.UPD_TARGET : bus.UPD_PC + FOUR) :
                             l_taken ? l_tgt : bus.PC + FOUR;
  assign bus.BR_COUNT      = br_cnt;
  assign bus.MISPRED_COUNT = mp_cnt;
  assign upd      = bus.UPD_VALID && bus.EN;
  assign u_wr     = upd && (u_hit || bus.UPD_TAKEN);
  assign u_w      = u_hit ? u_way : u_free ? u_inv : vptr_q[u_set];
  assign u_ctr    = ctr_q[u_set][u_w];
  assign u_ctr_nx = !u_hit ? 2'b10 :
                    bus.UPD_TAKEN ? (u_ctr == 2'b11 ? u_ctr : u_ctr + 2'b01) :
                    (u_ctr == 2'b00 ? u_ctr : u_ctr - 2'b01);
  assign push       = upd && bus.UPD_IS_CALL;
  assign pop        = upd && bus.UPD_KIND == 2'b10 && bus.UPD_TAKEN && ras_cnt != '0;
  assign ras_wr_idx = pop ? ras_top : ras_top + RAS_W'(1);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) ctr_q[s][w] <= 2'b00;
      end
      ras_top <= '0;
      ras_cnt <= '0;
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (upd) begin
      if (u_wr) begin
        valid_q[u_set][u_w] <= 1'b1;
        ctr_q[u_set][u_w] <= u_ctr_nx;
      end
      if (!u_hit && bus.UPD_TAKEN && !u_free)
        vptr_q[u_set] <= vptr_q[u_set] == WAY_W'(WAYS - 1) ? '0 : vptr_q[u_set] + WAY_W'(1);
      if (push && !pop) begin
        ras_top <= ras_top + RAS_W'(1);
        ras_cnt <= ras_cnt == (RAS_W+1)'(RAS_DEPTH) ? ras_cnt : ras_cnt + (RAS_W+1)'(1);
      end else if (pop && !push) begin
        ras_top <= ras_top - RAS_W'(1);
        ras_cnt <= ras_cnt - (RAS_W+1)'(1);
      end
      br_cnt <= br_cnt + 32'd1;
      mp_cnt <= mp_cnt + 32'(bus.UPD_MISPRED);
    end
  end
  // Payload storage is never reset; valid bits and RAS count gate its use.
  always_ff @(posedge CLK) begin
    if (u_wr) begin
      tag_q[u_set][u_w] <= u_tag;
      kind_q[u_set][u_w] <= bus.UPD_KIND;
      if (bus.UPD_TAKEN) tgt_q[u_set][u_w] <= bus.UPD_TARGET;
    end
    if (push) ras_q[ras_wr_idx] <= bus.UPD_PC + FOUR;
  end
endmodule
